bin_tape_loader: RTL and testbench

- Writer side of main memory. Consumes the PDP-8 BIN paper-tape byte stream from the serial receiver and writes the decoded 12-bit words into the 32K x 12 synchronous RAM through its single write port.
- Decodes leader/trailer, origin, data and field-setting frames, and verifies the tape checksum.
- Sits between the console receiver and the memory arbiter. Used to load programs without front-panel toggling.

---
 rtl/bin_tape_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_bin_tape_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_tape_loader.sv
// ---------------------------------------------------------------------------
// bin_tape_loader
//   Writer side of main memory. It takes a PDP-8 BIN paper-tape byte stream
//   from the console receiver, decodes the leader, origin, data, field-setting
//   and trailer frames, and writes the decoded 12-bit words into the 32K x 12
//   RAM through the memory arbiter. It also verifies the tape checksum.
//
//   Every data word is held "pending" until the next frame arrives. A data
//   frame that is followed by the trailer is the checksum, so it is never
//   written to memory.
//
// Optional feature (compile-time macro BIN_RUBOUT_EN):
//   When the macro is defined, byte 0xFF toggles an ignore flag. While the flag
//   is set, every byte is consumed and discarded. When the macro is undefined,
//   0xFF is treated like any other bit7=1 byte.
//
// Parameters:
//   addr_width  memory address width (15 = 3-bit field + 12-bit word; 13 keeps
//               only the low field bit)
//   data_width  memory word width, fixed at 12
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse that arms the loader
//   rx_data    tape byte
//   rx_valid   rx_data is valid
//   rx_ready   loader accepts the byte (a transfer needs rx_valid & rx_ready)
//   mem_req    memory port request to the arbiter
//   mem_gnt    arbiter grant
//   mem_addr   write address
//   mem_din    write data
//   mem_we     one-cycle write strobe
//   busy       loader armed or active
//   done       trailer reached; sticky until the next start
//   cksum_err  checksum mismatch or framing error; sticky until the next start
// ---------------------------------------------------------------------------
module bin_tape_loader #(
    parameter int addr_width = 15,
    parameter int data_width = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_din,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  cksum_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEADER, S_HIGH, S_LOW, S_WRITE, S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            field_q, field_d;
    logic [11:0]           origin_q, origin_d;
    logic [11:0]           sum_q, sum_d;
    logic [data_width-1:0] pend_word_q, pend_word_d;
    logic [addr_width-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]            pend_bsum_q, pend_bsum_d;  // sum of the pending frame's two bytes
    logic                  pend_vld_q, pend_vld_d;
    logic [5:0]            hi6_q, hi6_d;
    logic                  is_org_q, is_org_d;
    logic [6:0]            lo7_q, lo7_d;              // low byte of the frame waiting behind a commit
    logic                  frames_q, frames_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef BIN_RUBOUT_EN
    logic                  ign_q, ign_d;
`endif

    logic [14:0] full_addr;
    logic        accept;
    logic        take;     // accepted byte that the frame decoder actually sees

    // A 13-bit address keeps only the low bit of the field.
    assign full_addr = {field_q, origin_q};
    assign accept    = rx_valid & rx_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            field_q     <= '0;
            origin_q    <= '0;
            sum_q       <= '0;
            pend_word_q <= '0;
            pend_addr_q <= '0;
            pend_bsum_q <= '0;
            pend_vld_q  <= 1'b0;
            hi6_q       <= '0;
            is_org_q    <= 1'b0;
            lo7_q       <= '0;
            frames_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BIN_RUBOUT_EN
            ign_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            origin_q    <= origin_d;
            sum_q       <= sum_d;
            pend_word_q <= pend_word_d;
            pend_addr_q <= pend_addr_d;
            pend_bsum_q <= pend_bsum_d;
            pend_vld_q  <= pend_vld_d;
            hi6_q       <= hi6_d;
            is_org_q    <= is_org_d;
            lo7_q       <= lo7_d;
            frames_q    <= frames_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef BIN_RUBOUT_EN
            ign_q       <= ign_d;
`endif
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        origin_d    = origin_q;
        sum_d       = sum_q;
        pend_word_d = pend_word_q;
        pend_addr_d = pend_addr_q;
        pend_bsum_d = pend_bsum_q;
        pend_vld_d  = pend_vld_q;
        hi6_d       = hi6_q;
        is_org_d    = is_org_q;
        lo7_d       = lo7_q;
        frames_d    = frames_q;
        done_d      = done_q;
        err_d       = err_q;
`ifdef BIN_RUBOUT_EN
        ign_d       = ign_q;
        take        = accept && !ign_q && (rx_data != 8'hFF);
        if (accept && (rx_data == 8'hFF)) ign_d = !ign_q;
`else
        take        = accept;
`endif

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    sum_d      = '0;
                    origin_d   = '0;
                    field_d    = '0;
                    pend_vld_d = 1'b0;
                    frames_d   = 1'b0;
`ifdef BIN_RUBOUT_EN
                    ign_d      = 1'b0;
`endif
                    state_d    = S_LEADER;
                end else begin
                    state_d    = S_IDLE;
                end
            end

            S_LEADER: begin
                // The first byte with bit7 clear is already the high byte of frame one.
                if (take && !rx_data[7]) begin
                    hi6_d    = rx_data[5:0];
                    is_org_d = rx_data[6];
                    state_d  = S_LOW;
                end
            end

            S_HIGH: begin
                if (take) begin
                    if (rx_data == 8'h80) begin
                        // Trailer: whatever is still pending is the checksum word.
                        if (pend_vld_q) err_d = (sum_q != pend_word_q);
                        else            err_d = frames_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if ((rx_data & 8'hC7) == 8'hC0) begin
                        field_d = rx_data[5:3];
                    end else if (!rx_data[7]) begin
                        hi6_d    = rx_data[5:0];
                        is_org_d = rx_data[6];
                        state_d  = S_LOW;
                    end
                end
            end

            S_LOW: begin
                if (take) begin
                    if (rx_data[7]) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        frames_d = 1'b1;
                        if (is_org_q) begin
                            sum_d    = sum_q + 12'({2'b01, hi6_q}) + 12'(rx_data);
                            origin_d = {hi6_q, rx_data[5:0]};
                            state_d  = S_HIGH;
                        end else if (pend_vld_q) begin
                            // Commit the old word first; the new one follows in WRITE.
                            lo7_d   = rx_data[6:0];
                            state_d = S_WRITE;
                        end else begin
                            pend_word_d = {hi6_q, rx_data[5:0]};
                            pend_addr_d = full_addr[addr_width-1:0];
                            pend_bsum_d = {2'b00, hi6_q} + {1'b0, rx_data[6:0]};
                            pend_vld_d  = 1'b1;
                            origin_d    = origin_q + 12'd1;
                            state_d     = S_HIGH;
                        end
                    end
                end
            end

            S_WRITE: begin
                if (mem_gnt) begin
                    sum_d       = sum_q + 12'(pend_bsum_q);
                    pend_word_d = {hi6_q, lo7_q[5:0]};
                    pend_addr_d = full_addr[addr_width-1:0];
                    pend_bsum_d = {2'b00, hi6_q} + {1'b0, lo7_q};
                    origin_d    = origin_q + 12'd1;
                    state_d     = S_HIGH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        rx_ready  = (state_q == S_LEADER) || (state_q == S_HIGH) || (state_q == S_LOW);
        mem_req   = (state_q == S_WRITE);
        mem_we    = (state_q == S_WRITE) && mem_gnt;
        busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
        done      = done_q;
        cksum_err = err_q;
        mem_addr  = pend_addr_q;
        mem_din   = pend_word_q;
    end

endmodule

// File: tb/tb_bin_tape_loader.sv
module tb_bin_tape_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_req;
    logic        mem_gnt;
    logic [14:0] mem_addr;
    logic [11:0] mem_din;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        cksum_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  tape[$];
    logic [14:0] wr_addr[$];
    logic [11:0] wr_data[$];

    bin_tape_loader #(.addr_width(15), .data_width(12)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_we(mem_we), .busy(busy),
        .done(done), .cksum_err(cksum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_din);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_start();
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 0, 1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic run_tape();
        foreach (tape[i]) send_byte(tape[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic exp_write(input string tag, input int i, input logic [14:0] a, input logic [11:0] d);
        if (wr_addr.size() > i) begin
            chk({tag, "_addr"}, wr_addr[i], a);
            chk({tag, "_data"}, wr_data[i], d);
        end
    endtask

    int viol;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        mem_gnt  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cksum_err, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ready", rx_ready, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic tape: two data words plus correct checksum
        mem_gnt = 1'b1;
        do_start();
        chk("t1_busy", busy, 1);
        tape = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h41, 8'h00, 8'h12, 8'h34,
                 8'h3F, 8'h3F, 8'h04, 8'h05, 8'h80};
        run_tape();
        wait_idle();
        chk("t1_nwr", wr_addr.size(), 2);
        exp_write("t1_w0", 0, 15'h0040, 12'h4B4);
        exp_write("t1_w1", 1, 15'h0041, 12'hFFF);
        chk("t1_done", done, 1);
        chk("t1_err", cksum_err, 0);
        chk("t1_busy_end", busy, 0);

        // Same tape, wrong checksum
        do_start();
        chk("t2_cleared_done", done, 0);
        tape = '{8'h80, 8'h41, 8'h00, 8'h12, 8'h34, 8'h3F, 8'h3F, 8'h04, 8'h06, 8'h80};
        run_tape();
        wait_idle();
        chk("t2_nwr", wr_addr.size(), 2);
        exp_write("t2_w0", 0, 15'h0040, 12'h4B4);
        exp_write("t2_w1", 1, 15'h0041, 12'hFFF);
        chk("t2_done", done, 1);
        chk("t2_err", cksum_err, 1);

        // Field setting 0xD0 (field 2) then origin 0100, one data word
        do_start();
        tape = '{8'h80, 8'h41, 8'h00, 8'hD0, 8'h41, 8'h00, 8'h00, 8'h07, 8'h02, 8'h09, 8'h80};
        run_tape();
        wait_idle();
        chk("t3_nwr", wr_addr.size(), 1);
        exp_write("t3_w0", 0, 15'h2040, 12'h007);
        chk("t3_err", cksum_err, 0);
        chk("t3_done", done, 1);

        // Origin 07777 wraps to 0000 within the same field
        do_start();
        tape = '{8'h80, 8'h7F, 8'h3F, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03, 8'h01, 8'h80};
        run_tape();
        wait_idle();
        chk("t4_nwr", wr_addr.size(), 2);
        exp_write("t4_w0", 0, 15'h0FFF, 12'h001);
        exp_write("t4_w1", 1, 15'h0000, 12'h002);
        chk("t4_err", cksum_err, 0);

        // Grant withheld for 10 cycles during a commit
        mem_gnt = 1'b0;
        do_start();
        tape = '{8'h80, 8'h41, 8'h00, 8'h12, 8'h34, 8'h3F, 8'h3F};
        run_tape();
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || rx_ready !== 1'b0 || mem_we !== 1'b0) viol++;
        end
        chk("t5_hold_viol", viol, 0);
        chk("t5_nwr_hold", wr_addr.size(), 0);
        @(posedge clk);
        #1 mem_gnt = 1'b1;
        @(negedge clk);
        chk("t5_we", mem_we, 1);
        chk("t5_we_addr", mem_addr, 15'h0040);
        @(negedge clk);
        chk("t5_req_drop", mem_req, 0);
        chk("t5_we_drop", mem_we, 0);
        tape = '{8'h04, 8'h05, 8'h80};
        run_tape();
        wait_idle();
        chk("t5_nwr", wr_addr.size(), 2);
        chk("t5_err", cksum_err, 0);

        // Leader byte between high and low byte is a framing error
        do_start();
        tape = '{8'h80, 8'h41, 8'h00, 8'h12, 8'h80};
        run_tape();
        wait_idle();
        chk("t6_err", cksum_err, 1);
        chk("t6_done", done, 0);
        chk("t6_busy", busy, 0);
        chk("t6_nwr", wr_addr.size(), 0);

        // Reset in the middle of a commit aborts at once
        mem_gnt = 1'b0;
        do_start();
        tape = '{8'h80, 8'h41, 8'h00, 8'h12, 8'h34, 8'h3F, 8'h3F};
        run_tape();
        @(negedge clk);
        chk("t7_req_before", mem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("t7_req_async", mem_req, 0);
        chk("t7_busy_async", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_gnt = 1'b1;
        repeat (2) @(negedge clk);
        chk("t7_no_write", wr_addr.size(), 0);
        chk("t7_ready", rx_ready, 0);

`ifdef BIN_RUBOUT_EN
        // Bytes bracketed by 0xFF are discarded, even inside a frame
        do_start();
        tape = '{8'h80, 8'h41, 8'h00, 8'h12, 8'hFF, 8'h55, 8'h66, 8'hFF, 8'h34,
                 8'h3F, 8'h3F, 8'h04, 8'h05, 8'h80};
        run_tape();
        wait_idle();
        chk("t8_nwr", wr_addr.size(), 2);
        exp_write("t8_w0", 0, 15'h0040, 12'h4B4);
        exp_write("t8_w1", 1, 15'h0041, 12'hFFF);
        chk("t8_err", cksum_err, 0);
`else
        // 0xFF in HIGH is ignored; in LOW it is a framing error
        do_start();
        tape = '{8'h80, 8'h41, 8'h00, 8'hFF, 8'h00, 8'h07, 8'h01, 8'h08, 8'h80};
        run_tape();
        wait_idle();
        chk("t8_nwr", wr_addr.size(), 1);
        exp_write("t8_w0", 0, 15'h0040, 12'h007);
        chk("t8_err", cksum_err, 0);
        do_start();
        tape = '{8'h80, 8'h41, 8'hFF};
        run_tape();
        wait_idle();
        chk("t9_err", cksum_err, 1);
        chk("t9_done", done, 0);
`endif

        // Start while busy must not clear the loader's state
        do_start();
        tape = '{8'h80, 8'h41, 8'h00, 8'h00, 8'h07};
        run_tape();
        do_start();
        tape = '{8'h01, 8'h08, 8'h80};
        run_tape();
        wait_idle();
        chk("t10_nwr", wr_addr.size(), 1);
        exp_write("t10_w0", 0, 15'h0040, 12'h007);
        chk("t10_err", cksum_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
